// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the stack operation sequencer.
// Purpose:
//   - seq_state_t : the nine sequencer states.
//   - seq_op_t    : which operation the sequencer is currently running.
//   - DEFAULT_INT_VECTOR : PC loaded on hardware-interrupt entry.
//   - Stack word order: the HI half of a PC is pushed first, so the LO half
//     comes off the stack first when popping.
package stack_seq_pkg;

  localparam logic [31:0] DEFAULT_INT_VECTOR = 32'h0000_0020;

  typedef enum logic [3:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    PUSH_FLG,
    POP_FLG,
    POP_LO,
    POP_HI,
    POP_WAIT,
    LOAD
  } seq_state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CALL,
    OP_RET,
    OP_RTI,
    OP_INT
  } seq_op_t;

  // HI goes onto the stack first, so LO is the first word popped back.
  localparam seq_state_t FIRST_PUSH_STATE = PUSH_HI;
  localparam seq_state_t FIRST_POP_STATE  = POP_LO;

endpackage

// File: rtl/stack_op_sequencer.sv
// Multi-cycle controller sitting beside the execute stage.
// Sequences CALL, RET, RTI and hardware-interrupt entry as push/pop micro-ops
// to the memory stage, stalls fetch/decode while busy, redirects the PC at the
// end of every sequence and restores the flags on RTI. It also owns the
// pending-interrupt latch.
// Ports:
//   clk_i, reset_i          clock and synchronous active-high reset
//   call_req_i, ret_req_i,
//   rti_req_i               instruction requests from execute (RTI > RET > CALL)
//   interrupt_i             external interrupt pulse, latched until taken
//   call_target_i           CALL destination, sign-extended to PC width
//   pc_plus_one_i           return address pushed by CALL
//   pc_i                    resume address pushed by interrupt entry
//   flag_register_i         flags pushed by interrupt entry
//   mem_data_in_i           popped word, valid the cycle after mem_pop_o
//   mem_push_o, push_data_o push request and the word to push
//   mem_pop_o               pop request
//   pc_load_o, pc_load_value_o          PC redirect
//   flag_restore_o, flag_restore_value_o flag reload on RTI
//   stall_o, busy_o         sequencer not idle
//   flush_o                 squash younger instructions (LOAD cycle)
//   int_ack_o               interrupt entry complete (LOAD cycle)
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int unsigned       PC_W       = 32,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       FLAG_W     = 3,
  parameter logic [PC_W-1:0]   INT_VECTOR = DEFAULT_INT_VECTOR
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              call_req_i,
  input  logic              ret_req_i,
  input  logic              rti_req_i,
  input  logic              interrupt_i,
  input  logic [DATA_W-1:0] call_target_i,
  input  logic [PC_W-1:0]   pc_plus_one_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [FLAG_W-1:0] flag_register_i,
  input  logic [DATA_W-1:0] mem_data_in_i,
  output logic              mem_push_o,
  output logic              mem_pop_o,
  output logic [DATA_W-1:0] push_data_o,
  output logic              pc_load_o,
  output logic [PC_W-1:0]   pc_load_value_o,
  output logic              flag_restore_o,
  output logic [FLAG_W-1:0] flag_restore_value_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              int_ack_o,
  output logic              busy_o
);

  seq_state_t        state_q, state_d;
  seq_op_t           op_q, op_d;
  logic              int_pending_q, int_pending_d;
  logic [PC_W-1:0]   pc_saved_q, pc_saved_d;
  logic [FLAG_W-1:0] flags_saved_q, flags_saved_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [DATA_W-1:0] pop_lo_q, pop_lo_d;
  logic [DATA_W-1:0] pop_hi_q, pop_hi_d;
  logic [FLAG_W-1:0] pop_flags_q, pop_flags_d;

  // State and saved-register update. Reset drops straight back to IDLE, which
  // abandons any sequence in flight before it can load the PC or flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      op_q          <= OP_NONE;
      int_pending_q <= 1'b0;
      pc_saved_q    <= '0;
      flags_saved_q <= '0;
      target_q      <= '0;
      pop_lo_q      <= '0;
      pop_hi_q      <= '0;
      pop_flags_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      int_pending_q <= int_pending_d;
      pc_saved_q    <= pc_saved_d;
      flags_saved_q <= flags_saved_d;
      target_q      <= target_d;
      pop_lo_q      <= pop_lo_d;
      pop_hi_q      <= pop_hi_d;
      pop_flags_q   <= pop_flags_d;
    end
  end

  // Next-state logic and outputs. Outputs depend only on state and saved
  // registers, never directly on the request inputs. Popped words are
  // captured one state after the pop that produced them, since memory returns
  // data a cycle late. An interrupt seen in the same cycle that a pending one
  // is accepted keeps the latch set so it is not lost.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    int_pending_d = int_pending_q | interrupt_i;
    pc_saved_d    = pc_saved_q;
    flags_saved_d = flags_saved_q;
    target_d      = target_q;
    pop_lo_d      = pop_lo_q;
    pop_hi_d      = pop_hi_q;
    pop_flags_d   = pop_flags_q;

    mem_push_o           = 1'b0;
    mem_pop_o            = 1'b0;
    push_data_o          = '0;
    pc_load_o            = 1'b0;
    pc_load_value_o      = '0;
    flag_restore_o       = 1'b0;
    flag_restore_value_o = '0;
    flush_o              = 1'b0;
    int_ack_o            = 1'b0;
    busy_o               = (state_q != IDLE);
    stall_o              = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (rti_req_i || ret_req_i || call_req_i || int_pending_q) begin
          flags_saved_d = flag_register_i;
          target_d      = PC_W'($signed(call_target_i));
        end
        if (rti_req_i) begin
          op_d    = OP_RTI;
          state_d = POP_FLG;
        end else if (ret_req_i) begin
          op_d    = OP_RET;
          state_d = FIRST_POP_STATE;
        end else if (call_req_i) begin
          op_d       = OP_CALL;
          pc_saved_d = pc_plus_one_i;
          state_d    = FIRST_PUSH_STATE;
        end else if (int_pending_q) begin
          op_d          = OP_INT;
          pc_saved_d    = pc_i;
          int_pending_d = interrupt_i;
          state_d       = FIRST_PUSH_STATE;
        end
      end
      PUSH_HI: begin
        mem_push_o  = 1'b1;
        push_data_o = pc_saved_q[PC_W-1 -: DATA_W];
        state_d     = PUSH_LO;
      end
      PUSH_LO: begin
        mem_push_o  = 1'b1;
        push_data_o = pc_saved_q[DATA_W-1:0];
        state_d     = (op_q == OP_INT) ? PUSH_FLG : LOAD;
      end
      PUSH_FLG: begin
        mem_push_o  = 1'b1;
        push_data_o = DATA_W'(flags_saved_q);
        state_d     = LOAD;
      end
      POP_FLG: begin
        mem_pop_o = 1'b1;
        state_d   = FIRST_POP_STATE;
      end
      POP_LO: begin
        mem_pop_o = 1'b1;
        if (op_q == OP_RTI) begin
          pop_flags_d = mem_data_in_i[FLAG_W-1:0];
        end
        state_d = POP_HI;
      end
      POP_HI: begin
        mem_pop_o = 1'b1;
        pop_lo_d  = mem_data_in_i;
        state_d   = POP_WAIT;
      end
      POP_WAIT: begin
        pop_hi_d = mem_data_in_i;
        state_d  = LOAD;
      end
      LOAD: begin
        pc_load_o = 1'b1;
        flush_o   = 1'b1;
        state_d   = IDLE;
        case (op_q)
          OP_CALL: pc_load_value_o = target_q;
          OP_INT: begin
            pc_load_value_o = INT_VECTOR;
            int_ack_o       = 1'b1;
          end
          OP_RTI: begin
            pc_load_value_o      = PC_W'({pop_hi_q, pop_lo_q});
            flag_restore_o       = 1'b1;
            flag_restore_value_o = pop_flags_q;
          end
          default: pc_load_value_o = PC_W'({pop_hi_q, pop_lo_q});
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
